branch_recovery_queue: RTL

//  Parametrised front-end redirect and branch-recovery controller for the OoO MIPS core.
//  - Holds one checkpoint per in-flight conditional branch in a DEPTH-entry FIFO, allocated at decode and retired at ROB commit.
//  - Issues delay-slot-aware PC redirects for predicted-taken branches, direct jumps and JR.
//  - Issues a pipeline flush and recovery redirect on a mispredict.
//  - Streams resolved-branch feedback to the predictor.
//  - Sits between decode, the ROB commit ports and the fetch load-PC interface.

---
 rtl/branch_recovery_queue.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/branch_recovery_queue.sv
// Branch checkpoint FIFO with delay-slot-aware fetch redirects, JR hold/resolve,
// mispredict flush/recovery and resolved-branch feedback to the predictor.
module branch_recovery_queue #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 8,
  parameter int GHIST_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dec_valid,
  input  logic                      dec_stall,
  input  logic                      dec_is_cbranch,
  input  logic                      dec_is_jump,
  input  logic                      dec_is_jump_reg,
  input  logic [ADDR_WIDTH-1:0]     dec_pc,
  input  logic [ADDR_WIDTH-1:0]     dec_target,
  input  logic                      dec_pred_taken,
  input  logic [GHIST_WIDTH-1:0]    dec_ghist,
  input  logic [ADDR_WIDTH-1:0]     dec_recovery_target,
  output logic                      alloc_ready,
  input  logic                      commit_valid,
  input  logic                      commit_branch_valid,
  input  logic                      commit_branch_taken,
  input  logic                      jr_resolve_valid,
  input  logic [ADDR_WIDTH-1:0]     jr_target,
  output logic                      redirect_we,
  output logic [ADDR_WIDTH-1:0]     redirect_pc,
  output logic                      flush,
  output logic                      jr_stall,
  output logic                      fb_valid,
  output logic [ADDR_WIDTH-1:0]     fb_pc,
  output logic [GHIST_WIDTH-1:0]    fb_ghist,
  output logic                      fb_taken,
  output logic                      fb_correct,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic                      overflow_err,
  output logic                      underflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = 1;

  localparam logic [1:0] DIDLE    = 2'd0;
  localparam logic [1:0] DSLOT    = 2'd1;
  localparam logic [1:0] DJR_SLOT = 2'd2;
  localparam logic [1:0] DJR_WAIT = 2'd3;

  localparam logic [1:0] RIDLE  = 2'd0;
  localparam logic [1:0] RSLOT  = 2'd1;
  localparam logic [1:0] RFLUSH = 2'd2;

  logic [ADDR_WIDTH-1:0]  mem_pc  [DEPTH];
  logic [GHIST_WIDTH-1:0] mem_gh  [DEPTH];
  logic                   mem_prd [DEPTH];
  logic [ADDR_WIDTH-1:0]  mem_rec [DEPTH];

  logic [PW-1:0] wptr, rptr;
  logic [AW-1:0] head;
  logic          full, empty, accept, alloc_req, alloc, pop, mispredict, redir_start;
  logic [1:0]    dstate, rstate;

  logic [ADDR_WIDTH-1:0]  dtgt_p1, rec_tgt_p1, jr_pc_p1;
  logic                   jr_vld_p1;
  logic                   fb_vld_p1, fb_taken_p1, fb_correct_p1;
  logic [ADDR_WIDTH-1:0]  fb_pc_p1;
  logic [GHIST_WIDTH-1:0] fb_gh_p1;

  assign head        = rptr[AW-1:0];
  assign full        = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty       = (wptr == rptr);
  assign flush       = (rstate == RFLUSH);
  assign accept      = dec_valid & ~dec_stall & ~jr_stall & ~flush;
  assign alloc_req   = accept & dec_is_cbranch;
  assign alloc       = alloc_req & ~full;
  assign pop         = commit_branch_valid & ~empty;
  assign mispredict  = pop & (mem_prd[head] != commit_branch_taken);
  assign redir_start = (dec_is_cbranch & dec_pred_taken) | dec_is_jump;
  assign alloc_ready = ~full;
  assign occupancy   = wptr - rptr;

  // Queue pointers: advance on alloc/pop, collapse to empty on reset or flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (alloc) wptr <= wptr + PTR_ONE;
      if (pop)   rptr <= rptr + PTR_ONE;
    end
  end

  // Sticky error flags for dropped allocs and pops against an empty queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (alloc_req && full)            overflow_err  <= 1'b1;
      if (commit_branch_valid && empty) underflow_err <= 1'b1;
    end
  end

  // Checkpoint storage written at the tail on each accepted alloc.
  always_ff @(posedge clk) begin
    if (alloc) begin
      mem_pc[wptr[AW-1:0]]  <= dec_pc;
      mem_gh[wptr[AW-1:0]]  <= dec_ghist;
      mem_prd[wptr[AW-1:0]] <= dec_pred_taken;
      mem_rec[wptr[AW-1:0]] <= dec_recovery_target;
    end
  end

  // Predictor feedback stage: head entry registered one cycle after its pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_vld_p1     <= 1'b0;
      fb_pc_p1      <= '0;
      fb_gh_p1      <= '0;
      fb_taken_p1   <= 1'b0;
      fb_correct_p1 <= 1'b0;
    end else begin
      fb_vld_p1 <= pop;
      if (pop) begin
        fb_pc_p1      <= mem_pc[head];
        fb_gh_p1      <= mem_gh[head];
        fb_taken_p1   <= commit_branch_taken;
        fb_correct_p1 <= (mem_prd[head] == commit_branch_taken);
      end
    end
  end

  assign fb_valid   = fb_vld_p1;
  assign fb_pc      = fb_pc_p1;
  assign fb_ghist   = fb_gh_p1;
  assign fb_taken   = fb_taken_p1;
  assign fb_correct = fb_correct_p1;

  // Recovery FSM: mispredicted pop waits for its delay slot to retire, then flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rstate <= RIDLE;
    end else begin
      case (rstate)
        RIDLE:   if (mispredict) rstate <= RSLOT;
        RSLOT:   if (commit_valid) rstate <= RFLUSH;
        default: rstate <= RIDLE;
      endcase
    end
  end

  // Recovery target captured from the head entry that mispredicted.
  always_ff @(posedge clk) begin
    if (rstate == RIDLE && mispredict) rec_tgt_p1 <= mem_rec[head];
  end

  // Decode FSM: tracks delay slots of taken transfers and the JR resolve hold.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      dstate   <= DIDLE;
      jr_stall <= 1'b0;
    end else begin
      case (dstate)
        DIDLE: begin
          if (accept && redir_start)          dstate <= DSLOT;
          else if (accept && dec_is_jump_reg) dstate <= DJR_SLOT;
        end
        DSLOT:    if (accept) dstate <= DIDLE;
        DJR_SLOT: begin
          if (accept) begin
            dstate   <= DJR_WAIT;
            jr_stall <= 1'b1;
          end
        end
        default: begin
          if (jr_resolve_valid) begin
            dstate   <= DIDLE;
            jr_stall <= 1'b0;
          end
        end
      endcase
    end
  end

  // Taken-branch / jump target held until its delay slot is accepted.
  always_ff @(posedge clk) begin
    if (dstate == DIDLE && accept && redir_start) dtgt_p1 <= dec_target;
  end

  // JR redirect stage: resolved target issued the cycle after resolution.
  always_ff @(posedge clk) begin
    if (rst) jr_vld_p1 <= 1'b0;
    else     jr_vld_p1 <= (dstate == DJR_WAIT) & jr_resolve_valid & ~flush;
  end

  // JR target capture alongside the redirect valid.
  always_ff @(posedge clk) begin
    if (dstate == DJR_WAIT && jr_resolve_valid) jr_pc_p1 <= jr_target;
  end

  // Redirect mux: recovery flush beats JR, which beats delay-slot redirects.
  always_comb begin
    redirect_we = 1'b0;
    redirect_pc = '0;
    if (flush) begin
      redirect_we = 1'b1;
      redirect_pc = rec_tgt_p1;
    end else if (jr_vld_p1) begin
      redirect_we = 1'b1;
      redirect_pc = jr_pc_p1;
    end else if (dstate == DSLOT && accept) begin
      redirect_we = 1'b1;
      redirect_pc = dtgt_p1;
    end
  end

endmodule
